mem_wb_stage: RTL and testbench

Writeback-side pipeline stage of the RV32I core, directly downstream of the memory-access stage. It registers the memory stage's results into the MEM/WB register, extracts and extends load data by funct3 and byte offset, and selects the writeback value. It drives the register-file write port and the priorMEMdata forwarding path back into the memory stage. It also detects misaligned loads and counts retired instructions.

---
 rtl/mem_wb_stage.sv | 124 ++++++++++++
 tb/tb_mem_wb_stage.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage of the RV32I core: load extraction, writeback select,
// misaligned-load trap detection and the retired-instruction counter.
module mem_wb_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            Stall,
  input  logic            Flush,
  input  logic            MemValid,
  input  logic            RegWrite,
  input  logic            MemRead,
  input  logic [1:0]      MemToReg,
  input  logic [2:0]      Funct3,
  input  logic [4:0]      Rd,
  input  logic [XLEN-1:0] ALUresult,
  input  logic [XLEN-1:0] Readdata,
  input  logic [XLEN-1:0] PCplus4,
  output logic            WBRegWrite,
  output logic [4:0]      WBRd,
  output logic [XLEN-1:0] WBdata,
  output logic [XLEN-1:0] priorMEMdata,
  output logic            LoadMisaligned,
  output logic [63:0]     InstRet
);

  logic [1:0]      offset;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [XLEN-1:0] load_data;
  logic            align_bad;
  logic            mis;
  logic [XLEN-1:0] wb_next;
  logic            capture;

  logic            regwrite_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] wbdata_q;
  logic            mis_q;
  logic [63:0]     instret_q;

  assign offset   = ALUresult[1:0];
  assign half_sel = offset[1] ? Readdata[31:16] : Readdata[15:0];

  // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    byte_sel = Readdata[7:0];
    case (offset)
      2'd1:    byte_sel = Readdata[15:8];
      2'd2:    byte_sel = Readdata[23:16];
      2'd3:    byte_sel = Readdata[31:24];
      default: byte_sel = Readdata[7:0];
    endcase
  end

  always_comb begin
    load_data = Readdata;
    align_bad = 1'b0;
    case (Funct3)
      3'b000: load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001: begin
        load_data = {{16{half_sel[15]}}, half_sel};
        align_bad = offset[0];
      end
      3'b100: load_data = {24'd0, byte_sel};
      3'b101: begin
        load_data = {16'd0, half_sel};
        align_bad = offset[0];
      end
      // LW and the unused encodings all behave as a word load
      default: begin
        load_data = Readdata;
        align_bad = (offset != 2'b00);
      end
    endcase
  end

  assign mis = MemValid & MemRead & align_bad;

  always_comb begin
    wb_next = ALUresult;
    case (MemToReg)
      2'b01:   wb_next = load_data;
      2'b10:   wb_next = PCplus4;
      default: wb_next = ALUresult;
    endcase
  end

  // Flush outranks Stall; only a real capture can retire an instruction
  assign capture = ~Flush & ~Stall;

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      regwrite_q <= 1'b0;
      rd_q       <= '0;
      wbdata_q   <= '0;
      mis_q      <= 1'b0;
    end else if (Flush) begin
      regwrite_q <= 1'b0;
      mis_q      <= 1'b0;
    end else if (!Stall) begin
      regwrite_q <= MemValid & RegWrite & (Rd != 5'd0) & ~mis;
      rd_q       <= Rd;
      wbdata_q   <= wb_next;
      mis_q      <= mis;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      instret_q <= '0;
    else if (capture && MemValid && !mis)
      instret_q <= instret_q + 64'd1;
  end

  assign WBRegWrite     = regwrite_q;
  assign WBRd           = rd_q;
  assign WBdata         = wbdata_q;
  assign priorMEMdata   = wbdata_q;
  assign LoadMisaligned = mis_q;
  assign InstRet        = instret_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage: one task per scenario,
// expected values computed by hand.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst, Stall, Flush, MemValid, RegWrite, MemRead;
  logic [1:0]  MemToReg;
  logic [2:0]  Funct3;
  logic [4:0]  Rd;
  logic [31:0] ALUresult, Readdata, PCplus4;
  logic        WBRegWrite, LoadMisaligned;
  logic [4:0]  WBRd;
  logic [31:0] WBdata, priorMEMdata;
  logic [63:0] InstRet;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_ret = 64'd0;

  mem_wb_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .Stall(Stall), .Flush(Flush), .MemValid(MemValid),
    .RegWrite(RegWrite), .MemRead(MemRead), .MemToReg(MemToReg), .Funct3(Funct3),
    .Rd(Rd), .ALUresult(ALUresult), .Readdata(Readdata), .PCplus4(PCplus4),
    .WBRegWrite(WBRegWrite), .WBRd(WBRd), .WBdata(WBdata), .priorMEMdata(priorMEMdata),
    .LoadMisaligned(LoadMisaligned), .InstRet(InstRet)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic mv, input logic rw, input logic mr, input logic [1:0] m2r,
                       input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] alu,
                       input logic [31:0] rdata, input logic [31:0] pc4);
    MemValid = mv; RegWrite = rw; MemRead = mr; MemToReg = m2r; Funct3 = f3;
    Rd = rd; ALUresult = alu; Readdata = rdata; PCplus4 = pc4;
  endtask

  task automatic test_reset();
    rst = 1'b1; Stall = 1'b1; Flush = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 2'b01, 3'b010, 5'd7, 32'hDEAD_BEE0, 32'h1234_5678, 32'h44);
    step(); step();
    checks++; if (WBRegWrite !== 1'b0) begin errors++; $display("FAIL reset_wbregwrite: got %b want 0", WBRegWrite); end
    checks++; if (WBRd !== 5'd0) begin errors++; $display("FAIL reset_wbrd: got %0d want 0", WBRd); end
    checks++; if (WBdata !== 32'd0) begin errors++; $display("FAIL reset_wbdata: got %h want 0", WBdata); end
    checks++; if (priorMEMdata !== 32'd0) begin errors++; $display("FAIL reset_prior: got %h want 0", priorMEMdata); end
    checks++; if (LoadMisaligned !== 1'b0) begin errors++; $display("FAIL reset_mis: got %b want 0", LoadMisaligned); end
    checks++; if (InstRet !== 64'd0) begin errors++; $display("FAIL reset_instret: got %0d want 0", InstRet); end
    rst = 1'b0; Stall = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 2'b00, 3'b000, 5'd5, 32'h0000_1234, 32'hFFFF_FFFF, 32'h8);
    step(); exp_ret = 64'd1;
    checks++; if (WBRegWrite !== 1'b1) begin errors++; $display("FAIL first_wbregwrite: got %b want 1", WBRegWrite); end
    checks++; if (WBRd !== 5'd5) begin errors++; $display("FAIL first_wbrd: got %0d want 5", WBRd); end
    checks++; if (WBdata !== 32'h1234) begin errors++; $display("FAIL first_wbdata: got %h want 00001234", WBdata); end
    checks++; if (priorMEMdata !== 32'h1234) begin errors++; $display("FAIL first_prior: got %h want 00001234", priorMEMdata); end
    checks++; if (InstRet !== exp_ret) begin errors++; $display("FAIL first_instret: got %0d want %0d", InstRet, exp_ret); end
  endtask

  task automatic test_load_ext();
    logic [2:0]  f3s  [8] = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b101, 3'b001, 3'b010, 3'b101};
    logic [1:0]  offs [8] = '{2'd0, 2'd3, 2'd1, 2'd2, 2'd2, 2'd0, 2'd0, 2'd0};
    logic [31:0] exps [8] = '{32'hFFFF_FF81, 32'hFFFF_FF80, 32'h0000_007F, 32'hFFFF_80FF,
                              32'h0000_80FF, 32'h0000_7F81, 32'h80FF_7F81, 32'h0000_7F81};
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 1'b1, 2'b01, f3s[i], 5'd10, {30'h0000_0400, offs[i]}, 32'h80FF_7F81, 32'h0);
      step(); exp_ret++;
      checks++; if (WBdata !== exps[i]) begin errors++; $display("FAIL load_ext[%0d]: got %h want %h", i, WBdata, exps[i]); end
      checks++; if (WBRegWrite !== 1'b1 || LoadMisaligned !== 1'b0) begin errors++; $display("FAIL load_ext_flags[%0d]: got we=%b mis=%b want we=1 mis=0", i, WBRegWrite, LoadMisaligned); end
    end
    checks++; if (InstRet !== exp_ret) begin errors++; $display("FAIL load_ext_instret: got %0d want %0d", InstRet, exp_ret); end
  endtask

  task automatic test_misaligned();
    logic [2:0]  f3s [2] = '{3'b010, 3'b001};
    logic [31:0] adr [2] = '{32'h0000_1002, 32'h0000_1001};
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 1'b1, 2'b01, f3s[i], 5'd9, adr[i], 32'h1111_2222, 32'h0);
      step();
      checks++; if (LoadMisaligned !== 1'b1) begin errors++; $display("FAIL mis_pulse[%0d]: got %b want 1", i, LoadMisaligned); end
      checks++; if (WBRegWrite !== 1'b0) begin errors++; $display("FAIL mis_nowrite[%0d]: got %b want 0", i, WBRegWrite); end
      checks++; if (InstRet !== exp_ret) begin errors++; $display("FAIL mis_instret[%0d]: got %0d want %0d", i, InstRet, exp_ret); end
      drive(1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0);
      step();
      checks++; if (LoadMisaligned !== 1'b0) begin errors++; $display("FAIL mis_oneshot[%0d]: got %b want 0", i, LoadMisaligned); end
    end
    // A stall holds a pending trap high
    drive(1'b1, 1'b1, 1'b1, 2'b01, 3'b010, 5'd9, 32'h0000_2003, 32'h0, 32'h0);
    step();
    Stall = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0);
    step();
    checks++; if (LoadMisaligned !== 1'b1) begin errors++; $display("FAIL mis_stall_hold: got %b want 1", LoadMisaligned); end
    Stall = 1'b0;
    step();
    checks++; if (LoadMisaligned !== 1'b0) begin errors++; $display("FAIL mis_after_stall: got %b want 0", LoadMisaligned); end
  endtask

  task automatic test_stall_flush();
    drive(1'b1, 1'b1, 1'b0, 2'b10, 3'b000, 5'd1, 32'h0000_5555, 32'h0, 32'h0000_0100);
    step(); exp_ret++;
    checks++; if (WBdata !== 32'h100 || WBRd !== 5'd1) begin errors++; $display("FAIL jal_capture: got data=%h rd=%0d want 00000100 rd=1", WBdata, WBRd); end
    Stall = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 2'b00, 3'b000, 5'd2, 32'h0000_DEAD, 32'h0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (WBdata !== 32'h100 || WBRd !== 5'd1 || WBRegWrite !== 1'b1) begin errors++; $display("FAIL stall_hold[%0d]: got data=%h rd=%0d we=%b want 00000100 rd=1 we=1", k, WBdata, WBRd, WBRegWrite); end
      checks++; if (InstRet !== exp_ret) begin errors++; $display("FAIL stall_instret[%0d]: got %0d want %0d", k, InstRet, exp_ret); end
    end
    Stall = 1'b0;
    step(); exp_ret++;
    checks++; if (WBdata !== 32'hDEAD || WBRd !== 5'd2) begin errors++; $display("FAIL after_stall: got data=%h rd=%0d want 0000dead rd=2", WBdata, WBRd); end
    Stall = 1'b1; Flush = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 2'b00, 3'b000, 5'd3, 32'h0000_0033, 32'h0, 32'h0);
    step();
    checks++; if (WBRegWrite !== 1'b0) begin errors++; $display("FAIL flush_stall_bubble: got %b want 0", WBRegWrite); end
    checks++; if (InstRet !== exp_ret) begin errors++; $display("FAIL flush_instret: got %0d want %0d", InstRet, exp_ret); end
    Stall = 1'b0; Flush = 1'b0;
  endtask

  task automatic test_rd0_bubble();
    drive(1'b1, 1'b1, 1'b0, 2'b00, 3'b000, 5'd0, 32'h0000_0077, 32'h0, 32'h0);
    step(); exp_ret++;
    checks++; if (WBRegWrite !== 1'b0) begin errors++; $display("FAIL rd0_nowrite: got %b want 0", WBRegWrite); end
    checks++; if (WBdata !== 32'h77) begin errors++; $display("FAIL rd0_data: got %h want 00000077", WBdata); end
    checks++; if (InstRet !== exp_ret) begin errors++; $display("FAIL rd0_instret: got %0d want %0d", InstRet, exp_ret); end
    drive(1'b0, 1'b1, 1'b0, 2'b00, 3'b000, 5'd4, 32'h0000_0088, 32'h0, 32'h0);
    step();
    checks++; if (WBRegWrite !== 1'b0) begin errors++; $display("FAIL bubble_nowrite: got %b want 0", WBRegWrite); end
    checks++; if (InstRet !== exp_ret) begin errors++; $display("FAIL bubble_instret: got %0d want %0d", InstRet, exp_ret); end
    // MemToReg=11 behaves as ALUresult
    drive(1'b1, 1'b1, 1'b0, 2'b11, 3'b000, 5'd6, 32'h0000_0066, 32'hAAAA_AAAA, 32'hBBBB_BBBB);
    step(); exp_ret++;
    checks++; if (WBdata !== 32'h66 || WBRegWrite !== 1'b1) begin errors++; $display("FAIL m2r_reserved: got data=%h we=%b want 00000066 we=1", WBdata, WBRegWrite); end
  endtask

  task automatic test_midstream_reset();
    drive(1'b1, 1'b1, 1'b1, 2'b01, 3'b010, 5'd8, 32'h0000_3001, 32'h0, 32'h0);
    step();
    checks++; if (LoadMisaligned !== 1'b1) begin errors++; $display("FAIL midrst_pending: got %b want 1", LoadMisaligned); end
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 2'b00, 3'b000, 5'd8, 32'h0000_0099, 32'h0, 32'h0);
    step(); exp_ret = 64'd0;
    checks++; if (WBRegWrite !== 1'b0 || LoadMisaligned !== 1'b0 || WBdata !== 32'd0 || WBRd !== 5'd0) begin errors++; $display("FAIL midrst_clear: got we=%b mis=%b data=%h rd=%0d want all 0", WBRegWrite, LoadMisaligned, WBdata, WBRd); end
    checks++; if (InstRet !== exp_ret) begin errors++; $display("FAIL midrst_instret: got %0d want 0", InstRet); end
    rst = 1'b0;
  endtask

  task automatic test_wrap();
    drive(1'b1, 1'b1, 1'b0, 2'b00, 3'b000, 5'd12, 32'h0000_00AB, 32'h0, 32'h0);
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret_q;
    step();
    checks++; if (InstRet !== 64'd0) begin errors++; $display("FAIL wrap_instret: got %h want 0", InstRet); end
    step();
    checks++; if (InstRet !== 64'd1) begin errors++; $display("FAIL wrap_next: got %h want 1", InstRet); end
  endtask

  initial begin
    rst = 1'b1; Stall = 1'b0; Flush = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0);
    #2;
    test_reset();
    test_load_ext();
    test_misaligned();
    test_stall_flush();
    test_rd0_bubble();
    test_midstream_reset();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
